// File: rtl/pu_mc_pkg.sv
// ============================================================================
// Module : pu_mc_pkg
// Shared types, default widths and width helpers for the multi-cycle PU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package pu_mc_pkg;

    localparam int W_DEF      = 16;
    localparam int IM_AW_DEF  = 8;
    localparam int DM_AW_DEF  = 8;
    localparam int DM_LAT_DEF = 2;
    localparam int DM_LAT_MAX = 4;
    localparam int WAIT_W     = $clog2(DM_LAT_MAX);
    localparam int OP_W       = 4;
    localparam int RA_W       = 4;
    localparam int NREG       = 2 ** RA_W;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        EXEC  = 3'd1,
        MEM   = 3'd2,
        WB    = 3'd3,
        HALT  = 3'd4
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_NOP  = 4'h0,
        OP_LI   = 4'h1,
        OP_LH   = 4'h2,
        OP_LL   = 4'h3,
        OP_ADD  = 4'h4,
        OP_SUB  = 4'h5,
        OP_AND  = 4'h6,
        OP_OR   = 4'h7,
        OP_XOR  = 4'h8,
        OP_LD   = 4'h9,
        OP_ST   = 4'hA,
        OP_HALT = 4'hF
    } op_t;

    function automatic int imm_w(input int w);
        return w / 2;
    endfunction

    // Word = opcode | rd | max(imm, ra:rb) so both formats share one layout.
    function automatic int instr_w(input int w);
        return OP_W + RA_W + (((w / 2) > 2 * RA_W) ? (w / 2) : 2 * RA_W);
    endfunction

    function automatic bit dm_lat_legal(input int lat);
        return (lat >= 1) && (lat <= DM_LAT_MAX);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pu_mc_if.sv
// ============================================================================
// Module : pu_mc_if
// Write-back / status bus of pu_mc; PERF_CNT_EN adds the cycle/retire counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface pu_mc_if
    import pu_mc_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int IM_AW = IM_AW_DEF
);
    logic             we;
    logic [W-1:0]     wd;
    logic             halted;
    logic [IM_AW-1:0] pc_o;
`ifdef PERF_CNT_EN
    logic [31:0]      cyc_cnt;
    logic [31:0]      ins_cnt;

    modport master (output we, wd, halted, pc_o, cyc_cnt, ins_cnt);
    modport slave  (input  we, wd, halted, pc_o, cyc_cnt, ins_cnt);
`else
    modport master (output we, wd, halted, pc_o);
    modport slave  (input  we, wd, halted, pc_o);
`endif
endinterface

`default_nettype wire

// File: rtl/pu_dmem_lat.sv
// ============================================================================
// Module : pu_dmem_lat
// Single-port data RAM with synchronous write and a DM_LAT-deep read pipeline.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pu_dmem_lat
    import pu_mc_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int DM_AW  = DM_AW_DEF,
    parameter int DM_LAT = DM_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DM_AW-1:0] addr,
    input  logic [W-1:0]     wdata,
    input  logic             we,
    input  logic             re,
    output logic [W-1:0]     rdata,
    output logic             rd_valid
);
    logic [W-1:0] mem_q  [2**DM_AW];
    logic [W-1:0] data_q [DM_LAT];
    logic         vld_q  [DM_LAT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    for (genvar k = 0; k < DM_LAT; k++) begin : g_pipe
        if (k == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q[0] <= 1'b0;
                end else begin
                    vld_q[0] <= re;
                end
                if (re) begin
                    data_q[0] <= mem_q[addr];
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q[k] <= 1'b0;
                end else begin
                    vld_q[k] <= vld_q[k-1];
                end
                data_q[k] <= data_q[k-1];
            end
        end
    end

    assign rdata    = data_q[DM_LAT-1];
    assign rd_valid = vld_q[DM_LAT-1];

endmodule

`default_nettype wire

// File: rtl/pu_mc.sv
// ============================================================================
// Module : pu_mc
// Multi-cycle teaching-CPU core (FETCH/EXEC/MEM/WB). Optional: PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module pu_mc
    import pu_mc_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int IM_AW  = IM_AW_DEF,
    parameter int DM_AW  = DM_AW_DEF,
    parameter int DM_LAT = DM_LAT_DEF,
    parameter logic [(2**IM_AW)*instr_w(W)-1:0] PROG = '0
) (
    input  logic    clk,
    input  logic    rst,
    pu_mc_if.master bus
);
    localparam int IW    = instr_w(W);
    localparam int IMM_W = imm_w(W);
    localparam int HI_W  = W - IMM_W;

    if (!dm_lat_legal(DM_LAT) || (W % 2 != 0) || (DM_AW > W)) begin : g_bad_cfg
        $error("pu_mc: illegal configuration W=%0d DM_AW=%0d DM_LAT=%0d", W, DM_AW, DM_LAT);
    end

    state_t            state_q, state_d;
    logic [IM_AW-1:0]  pc_q, pc_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [W-1:0]      res_q, res_d;
    logic [W-1:0]      ldata_q, ldata_d;
    logic [W-1:0]      wd_q, wd_d;
    logic [RA_W-1:0]   wad_q, wad_d;
    logic              wen_q, wen_d;
    logic              dms_q, dms_d;
    logic              halted_q, halted_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic [W-1:0]      rf_q   [NREG];
    logic [IW-1:0]     w_imem [2**IM_AW];

    op_t               w_op;
    logic [RA_W-1:0]   w_rd, w_ra, w_rb;
    logic [IMM_W-1:0]  w_imm;
    logic [W-1:0]      w_a, w_b, w_s, w_alu;
    logic              w_wen, w_dms, w_dmwe, w_halt;
    logic              w_dm_we, w_dm_re, w_dm_valid, w_rf_we;
    logic [W-1:0]      w_dm_rdata, w_wb_val;

    for (genvar i = 0; i < 2**IM_AW; i++) begin : g_imem
        assign w_imem[i] = PROG[i*IW +: IW];
    end

    assign w_op  = op_t'(ir_q[IW-1 -: OP_W]);
    assign w_rd  = ir_q[IW-OP_W-1 -: RA_W];
    assign w_ra  = ir_q[2*RA_W-1 -: RA_W];
    assign w_rb  = ir_q[RA_W-1:0];
    assign w_imm = ir_q[IMM_W-1:0];
    assign w_a   = rf_q[w_ra];
    assign w_b   = rf_q[w_rb];
    assign w_s   = rf_q[w_rd];

    // Decoder + ALU; ld/st use the zero-extended immediate as the address.
    always_comb begin
        w_alu  = '0;
        w_wen  = 1'b0;
        w_dms  = 1'b0;
        w_dmwe = 1'b0;
        w_halt = 1'b0;
        case (w_op)
            OP_LI:   begin w_alu = {{HI_W{w_imm[IMM_W-1]}}, w_imm}; w_wen = 1'b1; end
            OP_LH:   begin w_alu = {w_imm, w_s[IMM_W-1:0]};         w_wen = 1'b1; end
            OP_LL:   begin w_alu = {w_s[W-1:IMM_W], w_imm};         w_wen = 1'b1; end
            OP_ADD:  begin w_alu = w_a + w_b;                       w_wen = 1'b1; end
            OP_SUB:  begin w_alu = w_a - w_b;                       w_wen = 1'b1; end
            OP_AND:  begin w_alu = w_a & w_b;                       w_wen = 1'b1; end
            OP_OR:   begin w_alu = w_a | w_b;                       w_wen = 1'b1; end
            OP_XOR:  begin w_alu = w_a ^ w_b;                       w_wen = 1'b1; end
            OP_LD:   begin w_alu = {{HI_W{1'b0}}, w_imm}; w_wen = 1'b1; w_dms = 1'b1; end
            OP_ST:   begin w_alu = {{HI_W{1'b0}}, w_imm}; w_dmwe = 1'b1; end
            OP_HALT: w_halt = 1'b1;
            default: ;
        endcase
    end

    assign w_wb_val = dms_q ? ldata_q : res_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        res_d    = res_q;
        ldata_d  = ldata_q;
        wd_d     = wd_q;
        wad_d    = wad_q;
        wen_d    = wen_q;
        dms_d    = dms_q;
        halted_d = halted_q;
        wait_d   = wait_q;
        w_dm_we  = 1'b0;
        w_dm_re  = 1'b0;
        w_rf_we  = 1'b0;
        case (state_q)
            FETCH: begin
                ir_d    = w_imem[pc_q];
                state_d = EXEC;
            end
            EXEC: begin
                res_d = w_alu;
                wad_d = w_rd;
                wen_d = w_wen;
                dms_d = w_dms;
                if (w_halt) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (w_dmwe) begin
                    w_dm_we = 1'b1;
                    pc_d    = pc_q + IM_AW'(1);
                    state_d = FETCH;
                end else if (w_dms) begin
                    w_dm_re = 1'b1;
                    wait_d  = WAIT_W'(DM_LAT - 1);
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - WAIT_W'(1);
                end else if (w_dm_valid) begin
                    ldata_d = w_dm_rdata;
                    state_d = WB;
                end
            end
            WB: begin
                w_rf_we = wen_q;
                wd_d    = w_wb_val;
                pc_d    = pc_q + IM_AW'(1);
                state_d = FETCH;
            end
            HALT: ;
            default: state_d = FETCH;
        endcase
        // A reset cycle must not leave side effects behind.
        if (rst) begin
            w_dm_we = 1'b0;
            w_dm_re = 1'b0;
            w_rf_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            res_q    <= '0;
            ldata_q  <= '0;
            wd_q     <= '0;
            wad_q    <= '0;
            wen_q    <= 1'b0;
            dms_q    <= 1'b0;
            halted_q <= 1'b0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            res_q    <= res_d;
            ldata_q  <= ldata_d;
            wd_q     <= wd_d;
            wad_q    <= wad_d;
            wen_q    <= wen_d;
            dms_q    <= dms_d;
            halted_q <= halted_d;
            wait_q   <= wait_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rf_we) begin
            rf_q[wad_q] <= w_wb_val;
        end
    end

    pu_dmem_lat #(
        .W      (W),
        .DM_AW  (DM_AW),
        .DM_LAT (DM_LAT)
    ) u_dmem (
        .clk      (clk),
        .rst      (rst),
        .addr     (w_alu[DM_AW-1:0]),
        .wdata    (w_s),
        .we       (w_dm_we),
        .re       (w_dm_re),
        .rdata    (w_dm_rdata),
        .rd_valid (w_dm_valid)
    );

    assign bus.we     = w_rf_we;
    assign bus.wd     = (state_q == WB) ? w_wb_val : wd_q;
    assign bus.halted = halted_q;
    assign bus.pc_o   = pc_q;

`ifdef PERF_CNT_EN
    logic [31:0] cyc_q;
    logic [31:0] ins_q;
    logic        w_retire;

    assign w_retire = (state_q == WB) || ((state_q == EXEC) && (w_halt || w_dmwe));

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if ((state_q != HALT) && (cyc_q != '1)) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (w_retire && (ins_q != '1)) begin
                ins_q <= ins_q + 32'd1;
            end
        end
    end

    assign bus.cyc_cnt = cyc_q;
    assign bus.ins_cnt = ins_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pu_mc.sv
// ============================================================================
// Module : tb_pu_mc
// Directed self-checking bench for pu_mc (optional PERF_CNT_EN checks).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pu_mc;

    // li r1,5 ; li r2,3 ; add r3,r1,r2 ; halt
    localparam logic [4095:0] PROG1 = 4096'({16'hF000, 16'h4312, 16'h1203, 16'h1105});
    // li r1,7 ; st r1,[0x10] ; ld r4,[0x10] ; halt
    localparam logic [4095:0] PROG2 = 4096'({16'hF000, 16'h9410, 16'hA110, 16'h1107});
    // li r1,0x81 ; lh r1,0x12 ; ll r1,0x34 ; add r2,r1,r1  (4-word imem)
    localparam logic [63:0]   PROG3 = {16'h4211, 16'h3134, 16'h2112, 16'h1181};

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pu_mc_if #(.W(16), .IM_AW(8)) bus_a ();
    pu_mc #(.PROG(PROG1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    pu_mc_if #(.W(16), .IM_AW(2)) bus_c ();
    pu_mc #(.IM_AW(2), .PROG(PROG3)) u_dut_c (
        .clk (clk),
        .rst (rst),
        .bus (bus_c)
    );

    logic        lat_we     [4];
    logic [15:0] lat_wd     [4];
    logic        lat_halted [4];
    logic [7:0]  lat_pc     [4];

    for (genvar g = 0; g < 4; g++) begin : g_lat
        pu_mc_if #(.W(16), .IM_AW(8)) bus ();
        pu_mc #(.DM_LAT(g + 1), .PROG(PROG2)) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign lat_we[g]     = bus.we;
        assign lat_wd[g]     = bus.wd;
        assign lat_halted[g] = bus.halted;
        assign lat_pc[g]     = bus.pc_o;
    end

    // Leaves the bench at the negedge inside cycle 1 (first FETCH).
    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 6;
        if (bus_a.we !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", bus_a.we); end
        if (bus_a.wd !== 16'h0) begin errors++; $display("FAIL reset_wd got %h want 0000", bus_a.wd); end
        if (bus_a.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b want 0", bus_a.halted); end
        if (bus_a.pc_o !== 8'h0) begin errors++; $display("FAIL reset_pc got %h want 00", bus_a.pc_o); end
        if (bus_c.pc_o !== 2'h0) begin errors++; $display("FAIL reset_pc_c got %h want 0", bus_c.pc_o); end
        if (lat_pc[3] !== 8'h0) begin errors++; $display("FAIL reset_pc_lat got %h want 00", lat_pc[3]); end
    endtask

    task automatic test_alu_prog();
        logic        exp_we;
        logic [15:0] exp_wd;
        logic [7:0]  exp_pc;
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            exp_we = (c == 3) || (c == 6) || (c == 9);
            exp_wd = (c < 3) ? 16'd0 : (c < 6) ? 16'd5 : (c < 9) ? 16'd3 : 16'd8;
            exp_pc = (c <= 3) ? 8'd0 : (c <= 6) ? 8'd1 : (c <= 9) ? 8'd2 : 8'd3;
            checks += 4;
            if (bus_a.we !== exp_we) begin errors++; $display("FAIL alu_we cyc=%0d got %0b want %0b", c, bus_a.we, exp_we); end
            if (bus_a.wd !== exp_wd) begin errors++; $display("FAIL alu_wd cyc=%0d got %h want %h", c, bus_a.wd, exp_wd); end
            if (bus_a.pc_o !== exp_pc) begin errors++; $display("FAIL alu_pc cyc=%0d got %h want %h", c, bus_a.pc_o, exp_pc); end
            if (bus_a.halted !== (c >= 12)) begin errors++; $display("FAIL alu_halted cyc=%0d got %0b want %0b", c, bus_a.halted, (c >= 12)); end
`ifdef PERF_CNT_EN
            if (c == 5 || c == 12 || c == 16) begin
                checks += 2;
                if (bus_a.cyc_cnt !== ((c == 5) ? 32'd4 : 32'd11)) begin
                    errors++; $display("FAIL perf_cyc cyc=%0d got %0d want %0d", c, bus_a.cyc_cnt, (c == 5) ? 4 : 11);
                end
                if (bus_a.ins_cnt !== ((c == 5) ? 32'd1 : 32'd4)) begin
                    errors++; $display("FAIL perf_ins cyc=%0d got %0d want %0d", c, bus_a.ins_cnt, (c == 5) ? 1 : 4);
                end
            end
`endif
            @(negedge clk);
        end
    endtask

    task automatic test_load_latency();
        logic        exp_we;
        logic [15:0] exp_wd;
        logic [7:0]  exp_pc;
        int          lat;
        do_reset();
        for (int c = 1; c <= 17; c++) begin
            for (int l = 0; l < 4; l++) begin
                lat    = l + 1;
                exp_we = (c == 3) || (c == 8 + lat);
                exp_wd = (c < 3) ? 16'd0 : 16'd7;
                exp_pc = (c <= 3) ? 8'd0 : (c <= 5) ? 8'd1 : (c <= 8 + lat) ? 8'd2 : 8'd3;
                checks += 4;
                if (lat_we[l] !== exp_we) begin errors++; $display("FAIL ld_we lat=%0d cyc=%0d got %0b want %0b", lat, c, lat_we[l], exp_we); end
                if (lat_wd[l] !== exp_wd) begin errors++; $display("FAIL ld_wd lat=%0d cyc=%0d got %h want %h", lat, c, lat_wd[l], exp_wd); end
                if (lat_pc[l] !== exp_pc) begin errors++; $display("FAIL ld_pc lat=%0d cyc=%0d got %h want %h", lat, c, lat_pc[l], exp_pc); end
                if (lat_halted[l] !== (c >= 11 + lat)) begin
                    errors++; $display("FAIL ld_halted lat=%0d cyc=%0d got %0b want %0b", lat, c, lat_halted[l], (c >= 11 + lat));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_load();
        logic exp_we;
        do_reset();
        // Cycle 9 is the second MEM cycle of the DM_LAT=4 load.
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            exp_we = (c == 3) || (c == 12);
            checks += 2;
            if (lat_we[3] !== exp_we) begin errors++; $display("FAIL rst_ld_we cyc=%0d got %0b want %0b", c, lat_we[3], exp_we); end
            if (c <= 3 && lat_pc[3] !== 8'h0) begin
                errors++; $display("FAIL rst_ld_pc cyc=%0d got %h want 00", c, lat_pc[3]);
            end else if (c > 3 && lat_wd[3] !== 16'd7) begin
                errors++; $display("FAIL rst_ld_wd cyc=%0d got %h want 0007", c, lat_wd[3]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_pc_wrap();
        logic [15:0] vals [4];
        logic [15:0] exp_wd;
        logic [1:0]  exp_pc;
        vals[0] = 16'hFF81; vals[1] = 16'h1281; vals[2] = 16'h1234; vals[3] = 16'h2468;
        do_reset();
        for (int c = 1; c <= 16; c++) begin
            exp_pc = 2'(((c - 1) / 3) % 4);
            exp_wd = (c < 3) ? 16'd0 : vals[((c / 3) - 1) % 4];
            checks += 3;
            if (bus_c.pc_o !== exp_pc) begin errors++; $display("FAIL wrap_pc cyc=%0d got %0d want %0d", c, bus_c.pc_o, exp_pc); end
            if (bus_c.we !== (c % 3 == 0)) begin errors++; $display("FAIL wrap_we cyc=%0d got %0b want %0b", c, bus_c.we, (c % 3 == 0)); end
            if (bus_c.wd !== exp_wd) begin errors++; $display("FAIL wrap_wd cyc=%0d got %h want %h", c, bus_c.wd, exp_wd); end
            @(negedge clk);
        end
    endtask

    initial begin
        rst    = 1'b1;
        checks = 0;
        errors = 0;
        test_reset();
        test_alu_prog();
        test_load_latency();
        test_reset_mid_load();
        test_pc_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
